mux_scan_n_to_1: RTL



---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_sel_n_to_1.sv | 22 ++
 rtl/mux_scan_n_to_1.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the scanning N:1 multiplexer.
// Holds the FSM state encoding, the mode encodings and the select-width helper.
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A 2-channel mux still needs a 1-bit select, so never return 0.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_sel_n_to_1.sv
// Combinational N_CH:1, W-bit channel selector.
// An index that names no channel (idx >= N_CH) yields all zeros.
module mux_sel_n_to_1 #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = 4
) (
    input  logic [N_CH*W-1:0] i,
    input  logic [SEL_W-1:0]  idx,
    output logic [W-1:0]      y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx) == k) begin
                y = i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_n_to_1.sv
// Registered N_CH:1 mux with a manual select path and an auto-scan mode that
// streams every channel out over a valid/ready handshake.
//
// Handshake: a word (y, y_sel) transfers on any rising edge where y_valid and
// out_ready are both high; while y_valid is high and out_ready is low, y and
// y_sel hold stable. In manual mode y_valid is held high and out_ready is ignored.
module mux_scan_n_to_1
    import mux_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] i,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              start,
    input  logic              out_ready,
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  y_sel,
    output logic              y_valid,
    output logic              busy,
    output logic              done
);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ch, ch_nxt;
    logic [SEL_W-1:0] mux_idx;
    logic [W-1:0]     mux_y;
    logic [W-1:0]     y_nxt;
    logic [SEL_W-1:0] y_sel_nxt;
    logic             y_valid_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             last_ch;
    logic             accept;
    logic             scan_go;

    // Terminate on the last index or anything beyond it, so the counter never wraps.
    assign last_ch = (int'(ch) >= N_CH - 1);
    assign accept  = y_valid & out_ready;
    // The done cycle is still part of the scan hand-off, so start is not honoured then.
    assign scan_go = (mode == MODE_SCAN) & start & ~done;

    // One shared selector: the next channel while scanning, sel in manual, 0 at scan start.
    always_comb begin
        mux_idx = '0;
        if (state == SCAN) begin
            mux_idx = ch + 1'b1;
        end else if (mode == MODE_MANUAL) begin
            mux_idx = sel;
        end
    end

    mux_sel_n_to_1 #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel (
        .i   (i),
        .idx (mux_idx),
        .y   (mux_y)
    );

    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        y_nxt       = y;
        y_sel_nxt   = y_sel;
        y_valid_nxt = y_valid;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (mode == MODE_MANUAL) begin
                    y_nxt       = mux_y;
                    y_sel_nxt   = sel;
                    y_valid_nxt = 1'b1;
                end else if (scan_go) begin
                    y_nxt       = mux_y;
                    y_sel_nxt   = '0;
                    y_valid_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                    ch_nxt      = '0;
                    state_nxt   = SCAN;
                end else begin
                    y_valid_nxt = 1'b0;
                end
            end

            SCAN: begin
                // Abort wins over a handshake in the same cycle; no done pulse.
                if (mode == MODE_MANUAL) begin
                    y_valid_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end else if (accept) begin
                    if (!last_ch) begin
                        ch_nxt    = ch + 1'b1;
                        y_nxt     = mux_y;
                        y_sel_nxt = ch + 1'b1;
                    end else begin
                        y_valid_nxt = 1'b0;
                        busy_nxt    = 1'b0;
                        done_nxt    = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end

            default: begin
                state_nxt   = IDLE;
                y_valid_nxt = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ch      <= '0;
            y       <= '0;
            y_sel   <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            y       <= y_nxt;
            y_sel   <= y_sel_nxt;
            y_valid <= y_valid_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule
